// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the memory-stage
//                request interface. It accepts one read or write, raises
//                Stall to freeze the requester, then completes the access
//                LAT cycles after acceptance with a one-cycle Done pulse.
//
//  Ports
//    clk     in   1   clock, all state changes on the rising edge
//    rst     in   1   synchronous active-high reset
//    Addr    in  16   byte address (must be even)
//    DataIn  in  16   write data
//    Rd      in   1   read request
//    Wr      in   1   write request
//    DataOut out 16   registered read data, held until the next read completes
//    Done    out  1   completion pulse, high for exactly one cycle
//    Stall   out  1   combinational; requester holds and freezes while high
//    err     out  1   combinational illegal-request flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam int         c_DEPTH    = 1 << ADDR_W;
    // Acceptance edge and the edge entering DONE are both part of the
    // latency, so the WAIT counter starts two below LAT.
    localparam logic [3:0] c_CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic [15:0]       r_mem [c_DEPTH];

    logic              w_idle;
    logic              w_legal;
    logic              w_illegal;
    logic              w_commit;
    logic              w_acc_wr;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [15:0]       w_acc_data;

    assign w_idle    = (r_state == c_ST_IDLE);
    assign w_legal   = w_idle & (Rd ^ Wr) & ~Addr[0];
    assign w_illegal = w_idle & ((Rd & Wr) | ((Rd | Wr) & Addr[0]));

    assign err   = w_illegal;
    assign Stall = w_legal | (r_state == c_ST_WAIT);
    assign Done  = (r_state == c_ST_DONE);

    // With LAT==1 the commit edge is the acceptance edge itself, so the
    // access must use the live inputs rather than the (not yet loaded) latch.
    assign w_acc_wr   = w_idle ? Wr               : r_op_wr;
    assign w_acc_addr = w_idle ? Addr[ADDR_W:1]   : r_addr;
    assign w_acc_data = w_idle ? DataIn           : r_data;

    // Upper address bits alias onto the array and are deliberately unused.
    generate
        if (ADDR_W < 15) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^Addr[15:ADDR_W+1];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_legal) begin
                    if (LAT == 1) begin
                        w_state_nxt = c_ST_DONE;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_ST_DONE: begin
                // The requester still shows its old request here; it is
                // never re-accepted because only IDLE accepts.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_data  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_legal) begin
                r_op_wr <= Wr;
                r_addr  <= Addr[ADDR_W:1];
                r_data  <= DataIn;
            end
        end
    end

    // Array contents survive reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_acc_wr) begin
            r_mem[w_acc_addr] <= w_acc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DataOut <= 16'd0;
        end else if (w_commit && !w_acc_wr) begin
            DataOut <= r_mem[w_acc_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. DUT 0 uses LAT=4,
//                DUT 1 uses LAT=1. Reference model: word-indexed memory
//                map plus the last read value per DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a_addr, a_din, a_dout, b_addr, b_din, b_dout;
    logic        a_rd, a_wr, a_done, a_stall, a_err;
    logic        b_rd, b_wr, b_done, b_stall, b_err;

    dmem_responder #(.ADDR_W(10), .LAT(4)) u_dut_a (
        .clk(clk), .rst(rst), .Addr(a_addr), .DataIn(a_din), .Rd(a_rd), .Wr(a_wr),
        .DataOut(a_dout), .Done(a_done), .Stall(a_stall), .err(a_err)
    );

    dmem_responder #(.ADDR_W(10), .LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .Addr(b_addr), .DataIn(b_din), .Rd(b_rd), .Wr(b_wr),
        .DataOut(b_dout), .Done(b_done), .Stall(b_stall), .err(b_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: key = dut*4096 + word address
    logic [15:0] mem_m [int];
    logic [15:0] dout_m [2];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] ad;
        logic [15:0] dn;
        logic        scr;
        logic        exp_err;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [15:0] o_dout(input int d);
        return (d == 0) ? a_dout : b_dout;
    endfunction
    function automatic logic o_done(input int d);
        return (d == 0) ? a_done : b_done;
    endfunction
    function automatic logic o_stall(input int d);
        return (d == 0) ? a_stall : b_stall;
    endfunction
    function automatic logic o_err(input int d);
        return (d == 0) ? a_err : b_err;
    endfunction

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [15:0] ad, input logic [15:0] dn);
        if (d == 0) begin
            a_rd = rd; a_wr = wr; a_addr = ad; a_din = dn;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = ad; b_din = dn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input int d, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, d, act, exp, $time);
    endtask

    task automatic chk16(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    endtask

    // One legal transaction, started in an IDLE cycle. Ends in the IDLE
    // cycle after Done with the old request still driven, so the caller can
    // present the next request back-to-back.
    task automatic txn(input int d, input logic wr, input logic [15:0] ad,
                       input logic [15:0] dn, input logic scr, output logic [15:0] got);
        int lat;
        int key;
        lat = (d == 0) ? 4 : 1;
        key = d * 4096 + int'(ad[10:1]);
        drive(1 - d, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(d, ~wr, wr, ad, dn);
        #1;
        chk1("accept_stall", d, o_stall(d), 1'b1);
        chk1("accept_err", d, o_err(d), 1'b0);
        chk1("accept_done", d, o_done(d), 1'b0);
        for (int k = 1; k < lat; k++) begin
            tick();
            if (scr) drive(d, 1'b0, 1'b1, 16'h0020, 16'hFFFF);
            #1;
            chk1("wait_stall", d, o_stall(d), 1'b1);
            chk1("wait_done", d, o_done(d), 1'b0);
        end
        tick();
        if (wr) mem_m[key] = dn;
        else if (mem_m.exists(key)) dout_m[d] = mem_m[key];
        chk1("done_pulse", d, o_done(d), 1'b1);
        chk1("done_stall", d, o_stall(d), 1'b0);
        got = o_dout(d);
        chk16("done_dataout", d, got, dout_m[d]);
        tick();
        chk1("done_one_cycle", d, o_done(d), 1'b0);
    endtask

    task automatic illegal(input int d, input logic rd, input logic wr,
                           input logic [15:0] ad, input int cycles);
        logic seen_done;
        logic seen_stall;
        drive(1 - d, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(d, rd, wr, ad, 16'hDEAD);
        #1;
        chk1("illegal_err", d, o_err(d), 1'b1);
        chk1("illegal_stall", d, o_stall(d), 1'b0);
        seen_done  = 1'b0;
        seen_stall = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            seen_done  = seen_done | o_done(d);
            seen_stall = seen_stall | o_stall(d);
        end
        chk1("illegal_no_done", d, seen_done, 1'b0);
        chk1("illegal_no_stall", d, seen_stall, 1'b0);
        chk16("illegal_dataout", d, o_dout(d), dout_m[d]);
        drive(d, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1);
    end

    initial begin
        logic [15:0] got;
        logic [9:0]  pool [2][6];
        logic [9:0]  w;
        logic [15:0] ad;
        int          d;
        int          sel;
        logic        rb;

        tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
        tbl[2]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'hBEEF};
        tbl[3]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234};
        tbl[4]  = '{1'b0, 1'b1, 16'h0022, 16'h5555, 1'b0, 1'b0, 16'h1234};
        tbl[5]  = '{1'b0, 1'b1, 16'h0004, 16'h0A0A, 1'b0, 1'b0, 16'h1234};
        tbl[6]  = '{1'b1, 1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, 16'h1234};
        tbl[7]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h1234};
        tbl[8]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 16'h0A0A};
        tbl[9]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
        tbl[10] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234};
        tbl[11] = '{1'b0, 1'b1, 16'h0030, 16'h1111, 1'b0, 1'b0, 16'h1234};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        dout_m[0] = 16'h0000;
        dout_m[1] = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk16("reset_dataout", i, o_dout(i), 16'h0000);
            chk1("reset_done", i, o_done(i), 1'b0);
            chk1("reset_stall", i, o_stall(i), 1'b0);
            chk1("reset_err", i, o_err(i), 1'b0);
        end

        // Directed table on the LAT=4 instance
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].exp_err) begin
                illegal(0, tbl[i].rd, tbl[i].wr, tbl[i].ad, 8);
            end else begin
                txn(0, tbl[i].wr, tbl[i].ad, tbl[i].dn, tbl[i].scr, got);
                chk16("table_dataout", 0, got, tbl[i].exp_dout);
            end
        end

        // Reset in the middle of a write: 0x0030 must keep 0x1111
        drive(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
        #1;
        chk1("rstmid_accept_stall", 0, o_stall(0), 1'b1);
        tick();
        tick();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        rst = 1'b0;
        dout_m[0] = 16'h0000;
        dout_m[1] = 16'h0000;
        chk1("rstmid_done", 0, o_done(0), 1'b0);
        chk1("rstmid_stall", 0, o_stall(0), 1'b0);
        chk16("rstmid_dataout", 0, o_dout(0), 16'h0000);
        tick();
        chk1("rstmid_no_late_done", 0, o_done(0), 1'b0);
        txn(0, 1'b0, 16'h0030, 16'h0000, 1'b0, got);
        chk16("rstmid_readback", 0, got, 16'h1111);

        // LAT=1: writes then back-to-back reads, alternating Stall/Done
        txn(1, 1'b1, 16'h0100, 16'h1357, 1'b0, got);
        txn(1, 1'b1, 16'h0102, 16'h2468, 1'b0, got);
        txn(1, 1'b0, 16'h0100, 16'h0000, 1'b0, got);
        chk16("lat1_read_a", 1, got, 16'h1357);
        txn(1, 1'b0, 16'h0102, 16'h0000, 1'b0, got);
        chk16("lat1_read_b", 1, got, 16'h2468);
        txn(1, 1'b0, 16'h0100, 16'h0000, 1'b0, got);
        chk16("lat1_read_c", 1, got, 16'h1357);

        // Randomized traffic against the reference model, with aliasing
        // through random upper address bits
        for (int dd = 0; dd < 2; dd++) begin
            for (int p = 0; p < 6; p++) begin
                pool[dd][p] = 10'($urandom);
                txn(dd, 1'b1, {5'($urandom), pool[dd][p], 1'b0}, 16'($urandom), 1'b0, got);
            end
        end
        for (int n = 0; n < 80; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            w   = pool[d][$urandom_range(0, 5)];
            ad  = {5'($urandom), w, 1'b0};
            rb  = 1'($urandom);
            if (sel == 0)      illegal(d, 1'b1, 1'b1, ad, 1);
            else if (sel == 1) illegal(d, rb, ~rb, ad | 16'h0001, 1);
            else               txn(d, (sel < 5), ad, 16'($urandom), 1'b0, got);
        end
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
